pipe_ctrl: RTL
==============

PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have parameters: MULT_CYC, default 5, mult/multu busy cycles; DIV_CYC, default 10, div/divu busy cycles; CNT_W, default 16, stall-counter width.
REQ-002 SHALL have one clock and an asynchronous, active-high reset, named clk and reset.
REQ-003 SHALL have ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous active-high reset.
- hz_stall  in  1  D-stage data hazard (load-use / Tuse<Tnew) from the hazard unit.
- md_start  in  1  E-stage mult/div issues this cycle.
- md_div  in  1  qualifies md_start: 1 = div/divu, 0 = mult/multu.
- md_need_D  in  1  D-stage instruction is mult/div/mfhi/mflo/mthi/mtlo.
- exc_req  in  1  CP0 exception/interrupt request.
- eret_D  in  1  eret is in D.
- stat_clr  in  1  synchronous clear of stall_cnt.
- pc_en  out  1  PC register enable.
- D_en  out  1  IF/ID register enable.
- D_clr  out  1  IF/ID flush.
- E_clr  out  1  ID/EX flush (bubble insert).
- req  out  1  pipeline-wide exception redirect to all stage registers.
- md_busy  out  1  MDU counter non-zero.
- md_done  out  1  one-cycle pulse, MDU result ready.
- stall_cnt  out  CNT_W  saturating count of stalled cycles.

Function
REQ-004 SHALL hold state RUN (count=0) or BUSY (count>0) in a down-counter wide enough for max(MULT_CYC, DIV_CYC).
REQ-005 SHALL, in RUN, on md_start=1 and exc_req=0, load the counter with DIV_CYC if md_div=1, else MULT_CYC, and enter BUSY at the next edge.
REQ-006 SHALL, in BUSY, decrement the counter each cycle; on a 1->0 transition, assert md_done for exactly that following cycle and return to RUN.
REQ-007 SHALL ignore md_start when exc_req=1 in the same cycle (the instruction is cancelled); an operation already in BUSY SHALL continue to completion regardless of exc_req.
REQ-008 SHALL ignore md_start while in BUSY; the counter is not reloaded.
REQ-009 SHALL drive md_busy = (count != 0), registered.
REQ-010 SHALL compute, combinationally, stall = hz_stall | (md_need_D & (md_busy | md_start)).
REQ-011 SHALL drive pc_en, D_en, D_clr, E_clr and req combinationally, in this priority:
- exc_req=1: req=1, pc_en=1, D_en=1, D_clr=0, E_clr=0.
- else stall=1: pc_en=0, D_en=0, D_clr=0, E_clr=1, req=0.
- else eret_D=1: pc_en=1, D_en=1, D_clr=1, E_clr=0, req=0.
- else: pc_en=1, D_en=1, D_clr=0, E_clr=0, req=0.
REQ-012 SHALL give stall priority over eret_D, so that an eret waiting on an EPC hazard is held and not flushed.
REQ-013 SHALL increment stall_cnt on every edge where stall=1 and exc_req=0.
REQ-014 SHALL saturate stall_cnt at 2^CNT_W-1, with no wrap.
REQ-015 SHALL give stat_clr priority over increment, so stall_cnt reads 0 after the edge.
REQ-016 SHALL have zero-cycle latency from inputs to pc_en/D_en/D_clr/E_clr/req, and one-edge latency on the counter, md_busy, md_done and stall_cnt.

Reset
REQ-017 SHALL, while reset=1, asynchronously force count=0, md_busy=0, md_done=0 and stall_cnt=0.
REQ-018 SHALL, while reset=1, force pc_en=0, D_en=0, D_clr=1, E_clr=1 and req=0, independent of all inputs.
REQ-019 SHALL abort an operation in progress when reset is asserted mid-BUSY, with no md_done pulse.
REQ-020 SHALL resume normal operation in RUN at the first rising edge after reset deasserts.

Verification
REQ-021 SHALL cover: md_start=1, md_div=0 at cycle 0 -> md_busy=1 for cycles 1..5, md_done=1 at cycle 6 only; same stimulus with md_div=1 -> md_busy for cycles 1..10, md_done=1 at cycle 11.
REQ-022 SHALL cover: md_start at cycle 0 and md_need_D=1 held -> pc_en=0, D_en=0, E_clr=1 for cycles 0..5; pc_en=1 at cycle 6; stall_cnt=6.
REQ-023 SHALL cover: md_start=1 with exc_req=1 in the same cycle -> req=1, md_busy stays 0, no md_done; exc_req at BUSY count=3 -> req=1 and md_done still fires on time.
REQ-024 SHALL cover: hz_stall=1 with eret_D=1 -> D_clr=0, E_clr=1; hz_stall then drops -> D_clr=1, pc_en=1; exc_req=1 with hz_stall=1 -> req=1, pc_en=1, E_clr=0.
REQ-025 SHALL cover: CNT_W=4 with hz_stall held 20 cycles -> stall_cnt stops at 15; stat_clr=1 together with stall -> stall_cnt=0 next cycle.
REQ-026 SHALL cover: reset asserted asynchronously mid-BUSY (count=4) -> md_busy=0, D_clr=1, E_clr=1 immediately, with no md_done pulse after release.

Source files
------------

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - pipeline stall/flush/redirect control with mult/div busy tracking
// The MDU down-counter doubles as the RUN (zero) / BUSY (non-zero) state.
module pipe_ctrl #(
  parameter int MULT_CYC = 5,
  parameter int DIV_CYC  = 10,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             hz_stall,
  input  logic             md_start,
  input  logic             md_div,
  input  logic             md_need_D,
  input  logic             exc_req,
  input  logic             eret_D,
  input  logic             stat_clr,
  output logic             pc_en,
  output logic             D_en,
  output logic             D_clr,
  output logic             E_clr,
  output logic             req,
  output logic             md_busy,
  output logic             md_done,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int MAX_CYC = (MULT_CYC > DIV_CYC) ? MULT_CYC : DIV_CYC;
  localparam int CW      = $clog2(MAX_CYC + 1);

  logic [CW-1:0]    r_count;
  logic             r_busy;
  logic             r_done;
  logic [CNT_W-1:0] r_stall_cnt;

  logic             w_stall;
  logic [CW-1:0]    w_load_val;

  assign w_stall    = hz_stall | (md_need_D & (r_busy | md_start));
  assign w_load_val = md_div ? CW'(DIV_CYC) : CW'(MULT_CYC);

  // A cancelled (exc_req) issue never loads; an op already counting runs to completion.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else if (r_count != '0) begin
      r_count <= r_count - CW'(1);
      r_busy  <= (r_count != CW'(1));
      r_done  <= (r_count == CW'(1));
    end else begin
      r_done <= 1'b0;
      if (md_start && !exc_req) begin
        r_count <= w_load_val;
        r_busy  <= (w_load_val != '0);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stall_cnt <= '0;
    end else if (stat_clr) begin
      r_stall_cnt <= '0;
    end else if (w_stall && !exc_req && (r_stall_cnt != {CNT_W{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  // Stall outranks eret so an eret waiting on an EPC hazard is held, not flushed.
  always_comb begin
    pc_en = 1'b1;
    D_en  = 1'b1;
    D_clr = 1'b0;
    E_clr = 1'b0;
    req   = 1'b0;
    if (reset) begin
      pc_en = 1'b0;
      D_en  = 1'b0;
      D_clr = 1'b1;
      E_clr = 1'b1;
    end else if (exc_req) begin
      req = 1'b1;
    end else if (w_stall) begin
      pc_en = 1'b0;
      D_en  = 1'b0;
      E_clr = 1'b1;
    end else if (eret_D) begin
      D_clr = 1'b1;
    end
  end

  assign md_busy   = r_busy;
  assign md_done   = r_done;
  assign stall_cnt = r_stall_cnt;

endmodule
